// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-stage register.
//   PC_BITS        : program-counter width of the CPU
//   DEFAULT_DATA_W : default lane payload (instruction + PC+4)
//   PERF_CNT_W     : width of the optional performance counters
//   pipe_state_t   : occupancy state of the two-entry stage
package pipe_stage_reg_pkg;

    localparam int unsigned PC_BITS        = 32;
    localparam int unsigned DEFAULT_DATA_W = 2 * PC_BITS;
    localparam int unsigned PERF_CNT_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry of the pipeline stage: {lane_valid, data} with load/clear.
// Ports:
//   clk          : clock, posedge
//   clear_i      : synchronous clear (mask <= 0, data <= RESET_DATA per lane)
//   load_i       : capture lane_valid_i / data_i
//   lane_valid_i : per-lane valid mask to store
//   data_i       : payload to store, lane i at [i*DATA_W +: DATA_W]
//   lane_valid_o : stored mask
//   data_o       : stored payload
module pipe_stage_reg_slot #(
    parameter int unsigned       LANES      = 1,
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                    clk,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [LANES-1:0]        lane_valid_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic [LANES-1:0]        lane_valid_o,
    output logic [LANES*DATA_W-1:0] data_o
);

    logic [LANES-1:0]        lane_valid_q;
    logic [LANES*DATA_W-1:0] data_q;

    // Clear wins over load; otherwise the entry holds its value.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            lane_valid_q <= '0;
            data_q       <= {LANES{RESET_DATA}};
        end else if (load_i) begin
            lane_valid_q <= lane_valid_i;
            data_q       <= data_i;
        end
    end

    assign lane_valid_o = lane_valid_q;
    assign data_o       = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with a two-entry skid buffer.
// The main entry drives the outputs; the skid entry absorbs one bundle when
// downstream stalls, so in_ready is a plain flop with no path from out_ready.
// Ports:
//   clk, rst (sync, active-high), clr (sync flush, active-high)
//   in_valid / in_ready / in_lane_valid / in_data     : upstream handshake
//   out_valid / out_ready / out_lane_valid / out_data : downstream handshake
//   perf_stall_cnt / perf_flush_cnt : counters, only with PIPE_STAGE_PERF_EN
//                                     defined; tied to 0 otherwise
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned       LANES      = 1,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [PERF_CNT_W-1:0]   perf_stall_cnt,
    output logic [PERF_CNT_W-1:0]   perf_flush_cnt
);

    if (LANES == 0 || DATA_W == 0) begin : g_bad_param
        $error("pipe_stage_reg: LANES and DATA_W must be >= 1");
    end

    pipe_state_t state_q, state_d;
    logic        in_ready_q;
    logic        out_valid_q;

    logic in_xfer_c;
    logic out_xfer_c;
    logic flush_c;
    logic main_load_c;
    logic main_from_skid_c;
    logic skid_load_c;

    logic [LANES-1:0]        skid_lane_valid;
    logic [LANES*DATA_W-1:0] skid_data;
    logic [LANES-1:0]        main_lane_valid_d;
    logic [LANES*DATA_W-1:0] main_data_d;

    assign in_xfer_c  = in_valid & in_ready_q;
    assign out_xfer_c = out_valid_q & out_ready;
    assign flush_c    = rst | clr;

    // Next-state and entry-load decode; flush overrides every handshake event.
    always_comb begin
        state_d          = state_q;
        main_load_c      = 1'b0;
        main_from_skid_c = 1'b0;
        skid_load_c      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer_c) begin
                    state_d     = ONE;
                    main_load_c = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer_c && out_xfer_c) begin
                    main_load_c = 1'b1;
                end else if (in_xfer_c) begin
                    state_d     = TWO;
                    skid_load_c = 1'b1;
                end else if (out_xfer_c) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer_c) begin
                    state_d          = ONE;
                    main_load_c      = 1'b1;
                    main_from_skid_c = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_c) begin
            state_d     = EMPTY;
            main_load_c = 1'b0;
            skid_load_c = 1'b0;
        end
    end

    // State plus its registered decodes (in_ready, out_valid).
    always_ff @(posedge clk) begin
        if (flush_c) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Main entry refills from skid when draining TWO, else from upstream.
    assign main_lane_valid_d = main_from_skid_c ? skid_lane_valid : in_lane_valid;
    assign main_data_d       = main_from_skid_c ? skid_data       : in_data;

    pipe_stage_reg_slot #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .clk          (clk),
        .clear_i      (flush_c),
        .load_i       (main_load_c),
        .lane_valid_i (main_lane_valid_d),
        .data_i       (main_data_d),
        .lane_valid_o (out_lane_valid),
        .data_o       (out_data)
    );

    pipe_stage_reg_slot #(
        .LANES      (LANES),
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clk          (clk),
        .clear_i      (flush_c),
        .load_i       (skid_load_c),
        .lane_valid_i (in_lane_valid),
        .data_i       (in_data),
        .lane_valid_o (skid_lane_valid),
        .data_o       (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;
    logic [PERF_CNT_W-1:0] flush_cnt_q;

    // Saturating counters; only rst clears them, clr leaves them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_q && !out_ready && !clr && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            end
            if (clr && (state_q != EMPTY) && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
